// File: rtl/apb_master_ctrl_if.sv
// Request/response handshake and APB bus signals of the bridge's APB initiator.
// The master modport is the initiator's view; the slave modport is the far side.
interface apb_master_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        busy;
   logic [31:0] Pselx;
   logic        Penable;
   logic        Pwrite;
   logic [31:0] Paddr;
   logic [31:0] Pwdata;
   logic [31:0] Prdata;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, Prdata,
      output req_ready, rsp_valid, rsp_rdata, busy,
             Pselx, Penable, Pwrite, Paddr, Pwdata
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, Prdata,
      input  req_ready, rsp_valid, rsp_rdata, busy,
             Pselx, Penable, Pwrite, Paddr, Pwdata
   );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB initiator: queues up to two read/write requests and runs each as a
// SETUP/ACCESS transfer, returning read data on a one-cycle response strobe.
module apb_master_ctrl #(
   parameter int unsigned SEL_LSB = 27,
   parameter int unsigned QDEPTH  = 2
) (
   input  logic              clk,
   input  logic              resetn,
   apb_master_ctrl_if.master bus
);
   localparam int unsigned AW = 32;
   localparam int unsigned DW = 32;
   localparam int unsigned SW = 5;
   localparam int unsigned CW = 2;

   typedef struct packed {
      logic          write;
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
   } req_t;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2
   } state_t;

   state_t        state, state_d;
   req_t          q_mem [0:1];
   req_t          head;
   logic          wr_ptr, rd_ptr;
   logic [CW-1:0] count, count_d;
   logic          push, pop;

   logic [AW-1:0] pselx_q, pselx_d;
   logic          penable_q, penable_d;
   logic          pwrite_q, pwrite_d;
   logic [AW-1:0] paddr_q, paddr_d;
   logic [DW-1:0] pwdata_q, pwdata_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
   logic          busy_q, busy_d;

   assign bus.req_ready = (count < CW'(QDEPTH));
   assign push          = bus.req_valid && bus.req_ready;
   // A pop happens exactly on the edges that enter SETUP.
   assign pop           = (state_d == SETUP);
   assign head          = q_mem[rd_ptr];

   always_comb begin
      count_d = count;
      if (push && !pop) begin
         count_d = count + CW'(1);
      end else if (!push && pop) begin
         count_d = count - CW'(1);
      end
   end

   // Two-entry request FIFO; storage is not reset, only the pointers.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) begin
            q_mem[wr_ptr] <= '{write: bus.req_write, addr: bus.req_addr, wdata: bus.req_wdata};
            wr_ptr        <= ~wr_ptr;
         end
         if (pop) begin
            rd_ptr <= ~rd_ptr;
         end
         count <= count_d;
      end
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state       <= IDLE;
         pselx_q     <= '0;
         penable_q   <= 1'b0;
         pwrite_q    <= 1'b0;
         paddr_q     <= '0;
         pwdata_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
         busy_q      <= 1'b0;
      end else begin
         state       <= state_d;
         pselx_q     <= pselx_d;
         penable_q   <= penable_d;
         pwrite_q    <= pwrite_d;
         paddr_q     <= paddr_d;
         pwdata_q    <= pwdata_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         busy_q      <= busy_d;
      end
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:    if (count != '0) state_d = SETUP;
         SETUP:   state_d = ACCESS;
         ACCESS:  state_d = (count != '0) ? SETUP : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      pselx_d     = pselx_q;
      penable_d   = 1'b0;
      pwrite_d    = pwrite_q;
      paddr_d     = paddr_q;
      pwdata_d    = pwdata_q;
      rsp_valid_d = 1'b0;
      rsp_rdata_d = rsp_rdata_q;
      busy_d      = (state_d != IDLE) || (count_d != '0);

      if (state == SETUP) begin
         penable_d = 1'b1;
      end

      // End of ACCESS: capture read data, then either reload or go idle.
      if (state == ACCESS) begin
         if (!pwrite_q) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = bus.Prdata;
         end
         if (!pop) begin
            pselx_d = '0;
         end
      end

      if (pop) begin
         paddr_d  = head.addr;
         pwrite_d = head.write;
         pselx_d  = AW'(1) << head.addr[SEL_LSB +: SW];
         if (head.write) begin
            pwdata_d = head.wdata;
         end
      end
   end

   assign bus.Pselx     = pselx_q;
   assign bus.Penable   = penable_q;
   assign bus.Pwrite    = pwrite_q;
   assign bus.Paddr     = paddr_q;
   assign bus.Pwdata    = pwdata_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.busy      = busy_q;
endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed and random requests, with a negedge
// monitor checking the APB bus and responses against a queue-based model.
module tb_apb_master_ctrl;
   logic clk    = 1'b0;
   logic resetn = 1'b0;
   always #5 clk = ~clk;

   apb_master_ctrl_if bus();
   apb_master_ctrl_if bus2();

   apb_master_ctrl #(.SEL_LSB(27), .QDEPTH(2)) dut (.clk(clk), .resetn(resetn), .bus(bus));
   apb_master_ctrl #(.SEL_LSB(12), .QDEPTH(2)) dut12 (.clk(clk), .resetn(resetn), .bus(bus2));

   function automatic logic [31:0] slave_data(logic [31:0] a);
      return a ^ 32'hEA34_567C;
   endfunction

   // Slave returns garbage outside ACCESS so a mistimed sample shows up.
   assign bus.Prdata  = bus.Penable ? slave_data(bus.Paddr) : ~slave_data(bus.Paddr);
   assign bus2.Prdata = 32'h0;

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] sel;
   } xfer_t;

   typedef enum int {PH_IDLE = 0, PH_SETUP = 1, PH_ACCESS = 2} phase_t;

   xfer_t       exp_apb[$];
   logic [31:0] exp_rsp[$];
   int          checks = 0;
   int          errors = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor / reference model: everything sampled at the negedge.
   initial begin
      phase_t      prev_ph, ph, exp_ph;
      int          prev_occ, occ, n_acc, n_start;
      xfer_t       cur, x;
      logic [31:0] last_wd, last_rd;
      logic        prev_rd_access;
      prev_ph = PH_IDLE; prev_occ = 0; n_acc = 0; n_start = 0;
      cur = '{1'b0, 32'h0, 32'h0, 32'h0};
      last_wd = 32'h0; last_rd = 32'h0; prev_rd_access = 1'b0;
      forever begin
         @(negedge clk);
         if (!resetn) begin
            exp_apb.delete();
            exp_rsp.delete();
            prev_ph = PH_IDLE; prev_occ = 0; n_acc = 0; n_start = 0;
            cur = '{1'b0, 32'h0, 32'h0, 32'h0};
            last_wd = 32'h0; last_rd = 32'h0; prev_rd_access = 1'b0;
            continue;
         end

         if (bus.Pselx == 32'h0)  ph = PH_IDLE;
         else if (!bus.Penable)   ph = PH_SETUP;
         else                     ph = PH_ACCESS;

         if (prev_ph == PH_SETUP) exp_ph = PH_ACCESS;
         else if (prev_occ > 0)   exp_ph = PH_SETUP;
         else                     exp_ph = PH_IDLE;
         chk("phase", 32'(ph), 32'(exp_ph));

         if (ph == PH_SETUP) begin
            if (exp_apb.size() == 0) begin
               chk("setup_unexpected", 32'd1, 32'd0);
            end else begin
               cur = exp_apb.pop_front();
               n_start++;
               chk("setup_pselx", bus.Pselx, cur.sel);
            end
         end else if (ph == PH_ACCESS) begin
            chk("access_pselx", bus.Pselx, cur.sel);
         end else begin
            chk("idle_penable", 32'(bus.Penable), 32'd0);
         end
         chk("paddr", bus.Paddr, cur.addr);
         chk("pwrite", 32'(bus.Pwrite), 32'(cur.wr));
         chk("pwdata", bus.Pwdata, cur.wdata);

         chk("rsp_valid", 32'(bus.rsp_valid), 32'(prev_rd_access));
         if (bus.rsp_valid && prev_rd_access) begin
            if (exp_rsp.size() == 0) chk("rsp_unexpected", 32'd1, 32'd0);
            else last_rd = exp_rsp.pop_front();
         end
         chk("rsp_rdata", bus.rsp_rdata, last_rd);

         occ = n_acc - n_start;
         chk("req_ready", 32'(bus.req_ready), 32'(occ < 2));
         chk("busy", 32'(bus.busy), 32'((ph != PH_IDLE) || (occ > 0)));

         prev_rd_access = (ph == PH_ACCESS) && !cur.wr;
         prev_ph  = ph;
         prev_occ = occ;

         // Request that will be accepted at the coming posedge.
         if (bus.req_valid && bus.req_ready) begin
            x.wr   = bus.req_write;
            x.addr = bus.req_addr;
            x.sel  = 32'h1 << ((bus.req_addr >> 27) & 32'd31);
            if (bus.req_write) last_wd = bus.req_wdata;
            x.wdata = last_wd;
            exp_apb.push_back(x);
            if (!bus.req_write) exp_rsp.push_back(slave_data(bus.req_addr));
            n_acc++;
         end
      end
   end

   // Call aligned to posedge+1; returns posedge+1 after the accepting edge.
   task automatic send(logic wr, logic [31:0] a, logic [31:0] d);
      int   n;
      logic acc;
      n = 0;
      bus.req_valid = 1'b1; bus.req_write = wr; bus.req_addr = a; bus.req_wdata = d;
      do begin
         @(negedge clk);
         acc = bus.req_ready;
         @(posedge clk); #1;
         n++;
      end while (!acc && n < 100);
      if (!acc) chk("send_timeout", 32'd1, 32'd0);
      bus.req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (bus.busy && n < 200) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 200) chk("drain_timeout", 32'd1, 32'd0);
      @(posedge clk); #1;
      chk("apb_left", 32'(exp_apb.size()), 32'd0);
      chk("rsp_left", 32'(exp_rsp.size()), 32'd0);
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;
      bus2.req_valid = 1'b0; bus2.req_write = 1'b0; bus2.req_addr = '0; bus2.req_wdata = '0;

      // Reset state
      resetn = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_pselx", bus.Pselx, 32'h0);
      chk("rst_penable", 32'(bus.Penable), 32'd0);
      chk("rst_pwrite", 32'(bus.Pwrite), 32'd0);
      chk("rst_paddr", bus.Paddr, 32'h0);
      chk("rst_pwdata", bus.Pwdata, 32'h0);
      chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
      resetn = 1'b1;
      step();

      // Single write
      send(1'b1, 32'h0800_0010, 32'hDEAD_BEEF);
      step();
      chk("wr_setup_pselx", bus.Pselx, 32'h0000_0002);
      chk("wr_setup_penable", 32'(bus.Penable), 32'd0);
      chk("wr_setup_pwrite", 32'(bus.Pwrite), 32'd1);
      chk("wr_setup_paddr", bus.Paddr, 32'h0800_0010);
      chk("wr_setup_pwdata", bus.Pwdata, 32'hDEAD_BEEF);
      step();
      chk("wr_access_penable", 32'(bus.Penable), 32'd1);
      step();
      chk("wr_idle_pselx", bus.Pselx, 32'h0);
      chk("wr_no_rsp", 32'(bus.rsp_valid), 32'd0);
      drain();

      // Single read
      send(1'b0, 32'hF800_0004, 32'h5555_5555);
      step();
      chk("rd_setup_pselx", bus.Pselx, 32'h8000_0000);
      chk("rd_setup_pwrite", 32'(bus.Pwrite), 32'd0);
      step();
      chk("rd_access_penable", 32'(bus.Penable), 32'd1);
      step();
      chk("rd_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("rd_rsp_rdata", bus.rsp_rdata, 32'h1234_5678);
      chk("rd_pwdata_held", bus.Pwdata, 32'hDEAD_BEEF);
      step();
      chk("rd_rsp_pulse_end", 32'(bus.rsp_valid), 32'd0);
      drain();

      // Back-to-back
      send(1'b1, 32'h0000_0000, 32'h1111_1111);
      send(1'b0, 32'h1000_0000, 32'h0);
      send(1'b1, 32'h1800_0000, 32'h3333_3333);
      drain();

      // Backpressure with four distinct requests
      send(1'b0, 32'h2000_0100, 32'h0);
      send(1'b1, 32'h2800_0200, 32'hA0A0_0001);
      send(1'b0, 32'h3000_0300, 32'h0);
      send(1'b1, 32'h3800_0400, 32'hA0A0_0002);
      drain();

      // Reset during ACCESS of a read with one entry queued
      send(1'b0, 32'h4000_0040, 32'h0);
      send(1'b1, 32'h4800_0048, 32'hCAFE_F00D);
      step();
      chk("mid_access_penable", 32'(bus.Penable), 32'd1);
      chk("mid_access_pwrite", 32'(bus.Pwrite), 32'd0);
      resetn = 1'b0;
      step();
      chk("mid_rst_pselx", bus.Pselx, 32'h0);
      chk("mid_rst_penable", 32'(bus.Penable), 32'd0);
      chk("mid_rst_paddr", bus.Paddr, 32'h0);
      chk("mid_rst_pwdata", bus.Pwdata, 32'h0);
      chk("mid_rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      chk("mid_rst_busy", 32'(bus.busy), 32'd0);
      chk("mid_rst_req_ready", 32'(bus.req_ready), 32'd1);
      resetn = 1'b1;
      repeat (8) step();
      chk("post_rst_idle", bus.Pselx, 32'h0);

      // Random traffic
      for (int i = 0; i < 150; i++) begin
         int gap;
         gap = $urandom_range(0, 3);
         if (gap == 3) gap = 0;
         repeat (gap) step();
         send(1'($urandom_range(0, 1)), $urandom, $urandom);
      end
      drain();

      // Narrow select field position
      bus2.req_valid = 1'b1; bus2.req_write = 1'b1;
      bus2.req_addr = 32'h0000_3000; bus2.req_wdata = 32'h0BAD_C0DE;
      step();
      bus2.req_valid = 1'b0;
      step();
      chk("sel12_pselx", bus2.Pselx, 32'h0000_0008);
      chk("sel12_penable", 32'(bus2.Penable), 32'd0);
      step();
      chk("sel12_access", 32'(bus2.Penable), 32'd1);
      repeat (2) step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/apb_master_ctrl.md
Name: apb_master_ctrl

Overview:
- APB initiator for the AHB-to-APB bridge: the opposite end of the APB interface from the slave-side responder, which drives Prdata.
- Accepts simple read/write requests from the bridge's AHB-side logic into a 2-entry request queue.
- Runs each request as an APB SETUP/ACCESS transfer, driving Pselx (one-hot), Penable, Pwrite, Paddr and Pwdata.
- Samples Prdata at the end of ACCESS and returns it on a response strobe. There is no Pready, so ACCESS is always exactly one cycle.

Parameters:
- SEL_LSB, 27: LSB of the 5-bit slave-select field. Index = req_addr[SEL_LSB+4:SEL_LSB]. Legal range 0..27.
- QDEPTH, 2: request queue depth. Fixed at 2; other values are not supported.

Ports:
- clk  input  1  bridge clock; all state updates on posedge.
- resetn  input  1  synchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  queue can accept; equals !full.
- req_write  input  1  1 = write, 0 = read.
- req_addr  input  32  transfer address.
- req_wdata  input  32  write data (ignored for reads).
- rsp_valid  output  1  one-cycle pulse: read data valid.
- rsp_rdata  output  32  captured Prdata.
- busy  output  1  high when state != IDLE or queue non-empty.
- Pselx  output  32  one-hot slave select.
- Penable  output  1  APB enable.
- Pwrite  output  1  APB direction.
- Paddr  output  32  APB address.
- Pwdata  output  32  APB write data.
- Prdata  input  32  APB read data from the selected slave.

Behaviour:
- Reset: clk is the only clock; resetn is synchronous and active-low.
  - resetn=0 sampled at a posedge: state=IDLE, queue flushed (count=0).
  - All outputs 0: Pselx, Penable, Pwrite, Paddr, Pwdata, rsp_valid, rsp_rdata, busy.
  - req_ready=1 from the first cycle after reset.
- Reset mid-transfer aborts immediately: Pselx/Penable drop at that edge, no rsp_valid is produced, and queued requests are lost.
- Request accept: push at a posedge when req_valid && req_ready. Queued entry is {write, addr, wdata}, FIFO order.
- req_ready is combinational on count only (count<2), independent of req_valid.
- Push and pop on the same edge is allowed when count=1; count stays 1 and order is preserved.
- FSM states: IDLE, SETUP, ACCESS.
  - IDLE: if count>0, pop the head and go to SETUP. Else stay.
  - SETUP: go to ACCESS unconditionally.
  - ACCESS: if count>0, pop the head and go to SETUP (back-to-back). Else go to IDLE.
- Output register load on pop:
  - Paddr <= addr, Pwrite <= write.
  - Pwdata <= wdata for writes; Pwdata holds its previous value for reads.
  - Pselx <= 1 << addr[SEL_LSB+4:SEL_LSB].
- Per-state outputs:
  - SETUP: Pselx one-hot, Penable=0.
  - ACCESS: Pselx unchanged, Penable=1.
  - Paddr, Pwrite and Pwdata are stable from SETUP through ACCESS.
- ACCESS→SETUP: Pselx is reloaded (it may change index), Penable=0. There is no idle gap.
- ACCESS→IDLE: Pselx=0, Penable=0. Paddr, Pwrite and Pwdata hold their last values.
- Latency:
  - Request accepted at edge E0 with an empty queue in IDLE: SETUP from E1, ACCESS from E2.
  - For a read, Prdata is sampled at E3. rsp_rdata is updated and rsp_valid=1 for the cycle E3..E4 only.
- Writes produce no rsp_valid. rsp_rdata holds its value between reads.
- Throughput: one transfer per 2 cycles when the queue stays non-empty.
- No response backpressure: the consumer must take rsp_valid when it pulses.
- busy = (state != IDLE) || (count > 0).

Test Plan:
- Single write:
  - Stimulus: req addr=0x0800_0010, wdata=0xDEAD_BEEF accepted at E0.
  - Required: E1 SETUP with Pselx=0x0000_0002, Penable=0, Pwrite=1, Paddr=0x0800_0010, Pwdata=0xDEAD_BEEF. E2 ACCESS with Penable=1. E3 IDLE with Pselx=0. No rsp_valid.
- Single read:
  - Stimulus: addr=0xF800_0004; slave drives Prdata=0x1234_5678 during ACCESS.
  - Required: Pselx=0x8000_0000, Pwrite=0. rsp_valid is a single-cycle pulse with rsp_rdata=0x1234_5678. Pwdata is unchanged.
- Back-to-back:
  - Stimulus: write 0x0000_0000, read 0x1000_0000, write 0x1800_0000 presented every cycle.
  - Required: req_ready drops when count=2. Cycles run SETUP/ACCESS×3 with no IDLE between them. Pselx sequence is 0x1, 0x4, 0x8. rsp_valid pulses only once.
- Backpressure:
  - Stimulus: hold req_valid=1 with 4 distinct requests.
  - Required: no request is lost or duplicated. APB order matches issue order. req_ready=0 exactly when count=2.
- Reset mid-ACCESS:
  - Stimulus: resetn=0 during the ACCESS of a read with 1 entry queued.
  - Required: at the next edge all outputs are 0, there is no rsp_valid, busy=0, and req_ready=1. After release the queued entry is never issued.
- SEL_LSB=12 build:
  - Stimulus: addr=0x0000_3000.
  - Required: Pselx=0x0000_0008.
